// File: rtl/fpga_cmd_pkg.sv
// Shared definitions for the FPGA command SPI link: word width, opcodes,
// master FSM states and the command-word packing helper.
package fpga_cmd_pkg;

   localparam int unsigned CMD_W = 16;

   localparam logic [3:0] FPGA_CMD_SET_CONFREG = 4'b0001;
   localparam logic [3:0] FPGA_CMD_SET_DIVISOR = 4'b0010;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StHigh,
      StLow,
      StGap
   } spi_state_e;

   function automatic logic [CMD_W-1:0] pack_cmd(input logic [3:0] op, input logic [7:0] data);
      return {op, 4'b0000, data};
   endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter timing one FSM phase; load with (duration - 1) on state entry.
module spi_phase_timer #(
   parameter int unsigned CNT_W = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_phase_done
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_phase_done = (r_cnt == '0);

endmodule

// File: rtl/fpga_cmd_spi_master.sv
// SPI mode-0 master serialising 16-bit FPGA command words onto spck/mosi/ncs,
// capturing miso into rx_word. All outputs are registered.
module fpga_cmd_spi_master
   import fpga_cmd_pkg::*;
#(
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned GAP_MULT = 2
) (
   input  logic             i_ck_1356meg,
   input  logic             i_reset,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [3:0]       i_cmd_op,
   input  logic [7:0]       i_cmd_data,
   input  logic [DIV_W-1:0] i_half_period,
   output logic             o_spck,
   output logic             o_mosi,
   output logic             o_ncs,
   input  logic             i_miso,
   output logic [CMD_W-1:0] o_rx_word,
   output logic             o_rx_valid,
   output logic             o_busy
);

   localparam int unsigned CNT_W    = DIV_W + 2;
   localparam logic [4:0]  LAST_BIT = 5'(CMD_W);

   spi_state_e       r_state;
   logic [CMD_W-1:0] r_tx_sr;
   logic [CMD_W-1:0] r_rx_sr;
   logic [4:0]       r_bit_cnt;
   logic [DIV_W-1:0] r_h;
   logic             r_ncs;
   logic             r_spck;
   logic             r_mosi;
   logic             r_ready;
   logic             r_busy;
   logic             r_rx_valid;
   logic [CMD_W-1:0] r_rx_word;

   logic [DIV_W-1:0] w_h_in;
   logic [CNT_W-1:0] w_h_ext;
   logic [CNT_W-1:0] w_gap_ext;
   logic             w_accept;
   logic             w_done;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;

   assign w_h_in    = (i_half_period == '0) ? DIV_W'(1) : i_half_period;
   assign w_h_ext   = CNT_W'(r_h);
   assign w_gap_ext = w_h_ext * CNT_W'(GAP_MULT);
   assign w_accept  = (r_state == StIdle) && i_cmd_valid && r_ready;

   // The timer is reloaded on every state change with the next state's duration.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = w_h_ext - CNT_W'(1);
      case (r_state)
         StIdle: begin
            w_load     = w_accept;
            w_load_val = CNT_W'(w_h_in) - CNT_W'(1);
         end
         StLow: begin
            w_load = w_done;
            if (r_bit_cnt == LAST_BIT) begin
               w_load_val = w_gap_ext - CNT_W'(1);
            end
         end
         default: w_load = w_done;
      endcase
   end

   spi_phase_timer #(
      .CNT_W(CNT_W)
   ) u_phase_timer (
      .i_clk       (i_ck_1356meg),
      .i_rst       (i_reset),
      .i_load      (w_load),
      .i_load_val  (w_load_val),
      .o_phase_done(w_done)
   );

   always_ff @(posedge i_ck_1356meg or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_tx_sr    <= '0;
         r_rx_sr    <= '0;
         r_bit_cnt  <= '0;
         r_h        <= DIV_W'(1);
         r_ncs      <= 1'b1;
         r_spck     <= 1'b0;
         r_mosi     <= 1'b0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_word  <= '0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_tx_sr   <= pack_cmd(i_cmd_op, i_cmd_data);
                  r_h       <= w_h_in;
                  r_bit_cnt <= '0;
                  r_ncs     <= 1'b0;
                  r_mosi    <= i_cmd_op[3];
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= StSetup;
               end
            end
            StSetup: begin
               if (w_done) begin
                  r_spck    <= 1'b1;
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  r_rx_sr   <= {r_rx_sr[CMD_W-2:0], i_miso};
                  r_state   <= StHigh;
               end
            end
            StHigh: begin
               if (w_done) begin
                  r_spck <= 1'b0;
                  // After the last bit mosi holds until ncs rises.
                  if (r_bit_cnt != LAST_BIT) begin
                     r_tx_sr <= {r_tx_sr[CMD_W-2:0], 1'b0};
                     r_mosi  <= r_tx_sr[CMD_W-2];
                  end
                  r_state <= StLow;
               end
            end
            StLow: begin
               if (w_done) begin
                  if (r_bit_cnt == LAST_BIT) begin
                     r_ncs      <= 1'b1;
                     r_mosi     <= 1'b0;
                     r_rx_word  <= r_rx_sr;
                     r_rx_valid <= 1'b1;
                     r_state    <= StGap;
                  end else begin
                     r_spck    <= 1'b1;
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                     r_rx_sr   <= {r_rx_sr[CMD_W-2:0], i_miso};
                     r_state   <= StHigh;
                  end
               end
            end
            StGap: begin
               if (w_done) begin
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_cmd_ready = r_ready;
   assign o_spck      = r_spck;
   assign o_mosi      = r_mosi;
   assign o_ncs       = r_ncs;
   assign o_rx_word   = r_rx_word;
   assign o_rx_valid  = r_rx_valid;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_fpga_cmd_spi_master.sv
// Directed bench for fpga_cmd_spi_master with a miso slave model and a
// configuration-receiver model on the far end of the link.
module tb_fpga_cmd_spi_master;
   import fpga_cmd_pkg::*;

   localparam int unsigned DIV_W    = 8;
   localparam int unsigned GAP_MULT = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_op;
   logic [7:0]       cmd_data;
   logic [DIV_W-1:0] hp;
   logic             spck;
   logic             mosi;
   logic             ncs;
   logic             miso = 1'b0;
   logic [15:0]      rx_word;
   logic             rx_valid;
   logic             busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fpga_cmd_spi_master #(
      .DIV_W   (DIV_W),
      .GAP_MULT(GAP_MULT)
   ) dut (
      .i_ck_1356meg (clk),
      .i_reset      (rst),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_op     (cmd_op),
      .i_cmd_data   (cmd_data),
      .i_half_period(hp),
      .o_spck       (spck),
      .o_mosi       (mosi),
      .o_ncs        (ncs),
      .i_miso       (miso),
      .o_rx_word    (rx_word),
      .o_rx_valid   (rx_valid),
      .o_busy       (busy)
   );

   // Edge counter; acc_pe is the accept edge, so a negedge sample is in cycle pe-acc_pe+1.
   int pe = 0;
   int acc_pe = 0;
   int acc_q[$];
   always @(posedge clk) begin
      pe = pe + 1;
      if (!rst && cmd_valid && cmd_ready) begin
         acc_pe = pe;
         acc_q.push_back(pe);
      end
   end

   logic        p_spck = 1'b0, p_ncs = 1'b1, p_ready = 1'b1, p_mosi = 1'b0;
   int          mon_cyc, rise_cnt, first_rise_cyc, fall_cyc, rxv_cnt, rxv_cyc, ready_cyc, m0_viol;
   logic [15:0] mon_word;
   logic [15:0] word_q[$];
   int          rcnt_q[$], low_len_q[$], rise_pe_q[$], fall_pe_q[$], rise_cyc_q[$];

   always @(negedge clk) begin
      mon_cyc = pe - acc_pe + 1;
      if (!ncs && p_ncs) begin
         fall_cyc = mon_cyc;
         fall_pe_q.push_back(pe);
         rise_cnt = 0;
      end
      if (spck && !p_spck) begin
         rise_cnt = rise_cnt + 1;
         mon_word = {mon_word[14:0], mosi};
         if (rise_cnt == 1) first_rise_cyc = mon_cyc;
      end
      if (spck && p_spck && (mosi !== p_mosi)) m0_viol = m0_viol + 1;
      if (ncs && !p_ncs) begin
         word_q.push_back(mon_word);
         rcnt_q.push_back(rise_cnt);
         low_len_q.push_back(mon_cyc - fall_cyc);
         rise_pe_q.push_back(pe);
         rise_cyc_q.push_back(mon_cyc);
      end
      if (rx_valid === 1'b1) begin
         rxv_cnt = rxv_cnt + 1;
         rxv_cyc = mon_cyc;
      end
      if (cmd_ready && !p_ready) ready_cyc = mon_cyc;
      p_spck  = spck;
      p_ncs   = ncs;
      p_ready = cmd_ready;
      p_mosi  = mosi;
   end

   // Slave: presents bit15 on ncs fall, shifts on each spck fall.
   logic [15:0] slave_word = 16'h0000;
   logic [15:0] slave_sh   = 16'h0000;
   always @(negedge ncs) begin
      slave_sh = slave_word;
      miso     = slave_sh[15];
   end
   always @(negedge spck) begin
      slave_sh = {slave_sh[14:0], 1'b0};
      miso     = slave_sh[15];
   end

   // Configuration receiver: samples on spck rise, latches on ncs rise.
   logic [15:0] rcv_sh   = 16'h0000;
   logic [7:0]  conf_reg = 8'h00;
   always @(posedge spck) rcv_sh = {rcv_sh[14:0], mosi};
   always @(posedge ncs) if (rcv_sh[15:12] == FPGA_CMD_SET_CONFREG) conf_reg = rcv_sh[7:0];

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      rise_cnt = 0; first_rise_cyc = 0; rxv_cnt = 0; rxv_cyc = 0;
      ready_cyc = 0; m0_viol = 0; mon_word = '0;
      word_q.delete(); rcnt_q.delete(); low_len_q.delete();
      rise_pe_q.delete(); fall_pe_q.delete(); rise_cyc_q.delete(); acc_q.delete();
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] d, input logic [DIV_W-1:0] h,
                        output bit ok);
      int n0;
      n0 = acc_q.size();
      ok = 1'b0;
      cmd_op = op; cmd_data = d; hp = h; cmd_valid = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         tick();
         if (acc_q.size() > n0) begin
            ok = 1'b1;
            break;
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         tick();
         if (ready_cyc != 0 && cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [15:0] qword(input int idx);
      return (word_q.size() > idx) ? word_q[idx] : 16'hxxxx;
   endfunction

   function automatic int qint(input int q[$], input int idx);
      return (q.size() > idx) ? q[idx] : -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; hp = 8'd1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++; if (ncs !== 1'b1) begin errors++; $display("FAIL reset_ncs: got %b want 1", ncs); end
      checks++; if (spck !== 1'b0) begin errors++; $display("FAIL reset_spck: got %b want 0", spck); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      checks++; if (rx_word !== 16'h0000) begin errors++; $display("FAIL reset_rx_word: got %h want 0000", rx_word); end
   endtask

   task automatic test_h1();
      bit ok;
      clear_mon();
      slave_word = 16'hC3A6;
      issue(4'h1, 8'hA5, 8'd1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL h1_accept: got timeout want accept"); end
      checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || ncs !== 1'b0 || mosi !== 1'b0) begin
         errors++; $display("FAIL h1_cycle1: got busy=%b ready=%b ncs=%b mosi=%b want 1 0 0 0",
                            busy, cmd_ready, ncs, mosi);
      end
      // A command offered while busy must be dropped.
      cmd_op = 4'hF; cmd_data = 8'hFF; cmd_valid = 1'b1;
      repeat (3) tick();
      cmd_valid = 1'b0;
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL h1_done: got timeout want ready"); end
      checks++; if (qword(0) !== 16'h10A5) begin errors++; $display("FAIL h1_word: got %h want 10a5", qword(0)); end
      checks++; if (qint(rcnt_q, 0) != 16) begin errors++; $display("FAIL h1_rises: got %0d want 16", qint(rcnt_q, 0)); end
      checks++; if (qint(low_len_q, 0) != 33) begin errors++; $display("FAIL h1_ncs_low: got %0d want 33", qint(low_len_q, 0)); end
      checks++; if (qint(rise_cyc_q, 0) != 34) begin errors++; $display("FAIL h1_ncs_rise: got %0d want 34", qint(rise_cyc_q, 0)); end
      checks++; if (first_rise_cyc != 2) begin errors++; $display("FAIL h1_first_rise: got %0d want 2", first_rise_cyc); end
      checks++; if (ready_cyc != 36) begin errors++; $display("FAIL h1_ready_cyc: got %0d want 36", ready_cyc); end
      checks++; if (rxv_cnt != 1) begin errors++; $display("FAIL h1_rxv_cnt: got %0d want 1", rxv_cnt); end
      checks++; if (rx_word !== 16'hC3A6) begin errors++; $display("FAIL h1_rx_word: got %h want c3a6", rx_word); end
      checks++; if (acc_q.size() != 1 || word_q.size() != 1) begin
         errors++; $display("FAIL h1_busy_ignore: got %0d accepts %0d words want 1 1", acc_q.size(), word_q.size());
      end
      checks++; if (m0_viol != 0) begin errors++; $display("FAIL h1_mode0: got %0d mosi changes with spck high want 0", m0_viol); end
   endtask

   task automatic test_hp0();
      bit ok;
      clear_mon();
      issue(4'h1, 8'hA5, 8'd0, ok);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL hp0_done: got timeout want ready"); end
      checks++; if (qword(0) !== 16'h10A5) begin errors++; $display("FAIL hp0_word: got %h want 10a5", qword(0)); end
      checks++; if (qint(low_len_q, 0) != 33) begin errors++; $display("FAIL hp0_ncs_low: got %0d want 33", qint(low_len_q, 0)); end
      checks++; if (first_rise_cyc != 2) begin errors++; $display("FAIL hp0_first_rise: got %0d want 2", first_rise_cyc); end
      checks++; if (ready_cyc != 36) begin errors++; $display("FAIL hp0_ready_cyc: got %0d want 36", ready_cyc); end
   endtask

   task automatic test_h4_capture();
      bit ok;
      clear_mon();
      slave_word = 16'hBEEF;
      issue(4'h2, 8'h5F, 8'd4, ok);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL h4_done: got timeout want ready"); end
      checks++; if (qword(0) !== 16'h205F) begin errors++; $display("FAIL h4_word: got %h want 205f", qword(0)); end
      checks++; if (rx_word !== 16'hBEEF) begin errors++; $display("FAIL h4_rx_word: got %h want beef", rx_word); end
      checks++; if (rxv_cnt != 1) begin errors++; $display("FAIL h4_rxv_cnt: got %0d want 1", rxv_cnt); end
      checks++; if (rxv_cyc != 133) begin errors++; $display("FAIL h4_rxv_cyc: got %0d want 133", rxv_cyc); end
      checks++; if (qint(rise_cyc_q, 0) != 133) begin errors++; $display("FAIL h4_ncs_rise: got %0d want 133", qint(rise_cyc_q, 0)); end
      checks++; if (first_rise_cyc != 5) begin errors++; $display("FAIL h4_first_rise: got %0d want 5", first_rise_cyc); end
      checks++; if (ready_cyc != 141) begin errors++; $display("FAIL h4_ready_cyc: got %0d want 141", ready_cyc); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_mon();
      cmd_op = 4'h1; cmd_data = 8'h11; hp = 8'd2; cmd_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (acc_q.size() == 1) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL b2b_first_accept: got timeout want accept"); end
      ok = 1'b0;
      for (int n = 1; n < 500; n++) begin
         tick();
         if (n == 10) begin hp = 8'd7; cmd_op = 4'h2; cmd_data = 8'h22; end
         if (n == 60) hp = 8'd2;
         if (acc_q.size() == 2) begin ok = 1'b1; break; end
      end
      cmd_valid = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL b2b_second_accept: got timeout want accept"); end
      for (int i = 0; i < 500; i++) begin
         tick();
         if (word_q.size() == 2 && cmd_ready) break;
      end
      checks++; if (qint(acc_q, 1) - qint(acc_q, 0) != 71) begin
         errors++; $display("FAIL b2b_accept_cyc: got %0d want 71", qint(acc_q, 1) - qint(acc_q, 0));
      end
      checks++; if (qword(0) !== 16'h1011) begin errors++; $display("FAIL b2b_word0: got %h want 1011", qword(0)); end
      checks++; if (qword(1) !== 16'h2022) begin errors++; $display("FAIL b2b_word1: got %h want 2022", qword(1)); end
      checks++; if (qint(low_len_q, 0) != 66) begin errors++; $display("FAIL b2b_ncs_low0: got %0d want 66", qint(low_len_q, 0)); end
      checks++; if (qint(low_len_q, 1) != 66) begin errors++; $display("FAIL b2b_ncs_low1: got %0d want 66", qint(low_len_q, 1)); end
      checks++; if (qint(fall_pe_q, 1) - qint(rise_pe_q, 0) != 5) begin
         errors++; $display("FAIL b2b_ncs_gap: got %0d want 5", qint(fall_pe_q, 1) - qint(rise_pe_q, 0));
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_mon();
      issue(4'h1, 8'h5A, 8'd2, ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (rise_cnt >= 5) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL rmid_rises: got %0d want 5", rise_cnt); end
      #2 rst = 1'b1;
      #1;
      checks++; if (ncs !== 1'b1 || spck !== 1'b0 || mosi !== 1'b0) begin
         errors++; $display("FAIL rmid_async: got ncs=%b spck=%b mosi=%b want 1 0 0", ncs, spck, mosi);
      end
      repeat (2) tick();
      checks++; if (rxv_cnt != 0 || rx_valid !== 1'b0) begin
         errors++; $display("FAIL rmid_no_rxv: got %0d pulses want 0", rxv_cnt);
      end
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rx_word !== 16'h0000) begin
         errors++; $display("FAIL rmid_state: got ready=%b busy=%b rx=%h want 1 0 0000", cmd_ready, busy, rx_word);
      end
      rst = 1'b0;
      tick();
      clear_mon();
      issue(4'h2, 8'h3C, 8'd1, ok);
      wait_done(ok);
      checks++; if (qword(0) !== 16'h203C) begin errors++; $display("FAIL rmid_word: got %h want 203c", qword(0)); end
      checks++; if (qint(rcnt_q, 0) != 16) begin errors++; $display("FAIL rmid_rises_after: got %0d want 16", qint(rcnt_q, 0)); end
   endtask

   task automatic test_loopback();
      bit ok;
      clear_mon();
      issue(FPGA_CMD_SET_CONFREG, 8'h05, 8'd1, ok);
      wait_done(ok);
      checks++; if (conf_reg !== 8'h05) begin errors++; $display("FAIL loop_confreg: got %h want 05", conf_reg); end
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: got no completion want finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "bench timed out");
   end

   initial begin
      test_reset();
      test_h1();
      test_hp0();
      test_h4_capture();
      test_back_to_back();
      test_reset_mid();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
